// File: rtl/cell_wr_scheduler_pkg.sv
// Shared constants and state encoding for the cell write scheduler.
package cell_pkg;

  localparam int AW_DEF       = 3;
  localparam int DW_DEF       = 3;
  localparam int MAX_WR_DEF   = 8;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int V_ACTIVE_DEF = V_RES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_INIT  = 2'd3
  } state_e;

endpackage

// File: rtl/cell_wr_scheduler_if.sv
// Request/colour inputs, VGA line position and RAM write-port outputs.
interface cell_wr_if #(
  parameter int AW = 3,
  parameter int DW = 3
);
  logic [(1<<AW)-1:0]    req;
  logic [(1<<AW)*DW-1:0] cell_color;
  logic [8:0]            vga_posY;
  logic [(1<<AW)-1:0]    ack;
  logic [AW-1:0]         mem_px_addr;
  logic [DW-1:0]         mem_px_data;
  logic                  px_wr;
  logic                  busy;
  logic                  frame_sync;

  modport master (
    output req, cell_color, vga_posY,
    input  ack, mem_px_addr, mem_px_data, px_wr, busy, frame_sync
  );

  modport slave (
    input  req, cell_color, vga_posY,
    output ack, mem_px_addr, mem_px_data, px_wr, busy, frame_sync
  );
endinterface

// File: rtl/cell_wr_scheduler_rr_pick.sv
// Round-robin priority finder: first set pending bit at or above rr_ptr_i,
// wrapping modulo 2**AW.
module rr_pick #(
  parameter int AW = 3
) (
  input  logic [(1<<AW)-1:0] pending_i,
  input  logic [AW-1:0]      rr_ptr_i,
  output logic               valid_o,
  output logic [AW-1:0]      index_o
);
  localparam int N = 1 << AW;

  logic [AW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = rr_ptr_i;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = rr_ptr_i + AW'(k);
      if (pending_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end
endmodule

// File: rtl/cell_wr_scheduler.sv
// Cell write scheduler: latches per-cell colour updates and writes them to
// the pixel buffer only during vertical blanking, round-robin.
// Optional macro CELL_WR_INIT_EN: after reset, clear all cells to colour 0.
//
// state | meaning
// IDLE  | waiting for blanking entry with work pending
// GRANT | pick next pending cell, register address/data
// WRITE | single-cycle RAM write strobe
// INIT  | post-reset clear of every address (CELL_WR_INIT_EN only)
module cell_wr_scheduler
  import cell_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int MAX_WR   = MAX_WR_DEF
) (
  input logic      clk,
  input logic      rst,
  cell_wr_if.slave bus
);
  localparam int N   = 1 << AW;
  localparam int WCW = $clog2(MAX_WR + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [DW-1:0]  shadow_q [N];
  logic [AW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d, wr_cnt_inc;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [N-1:0]   ack_q;
  logic           vblank, vblank_q, rise, frame_sync_q;
  logic           pick_valid;
  logic [AW-1:0]  pick_idx;
`ifdef CELL_WR_INIT_EN
  logic           init_q, init_d;
`endif

  assign vblank     = (bus.vga_posY >= 9'(V_ACTIVE));
  assign rise       = vblank & ~vblank_q;
  assign wr_cnt_inc = wr_cnt_q + WCW'(1);

  rr_pick #(.AW(AW)) u_pick (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  // Next-state, capture merge and write sequencing.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | bus.req;
    rr_ptr_d  = rr_ptr_q;
    wr_cnt_d  = rise ? '0 : wr_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef CELL_WR_INIT_EN
    init_d    = init_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef CELL_WR_INIT_EN
        if (init_q) begin
          state_d = ST_INIT;
          addr_d  = '0;
          data_d  = '0;
        end else
`endif
        if (rise && (pending_q != '0)) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (pick_valid) begin
          addr_d              = pick_idx;
          data_d              = shadow_q[pick_idx];
          // A request landing in this cycle keeps the cell pending.
          pending_d[pick_idx] = bus.req[pick_idx];
          state_d             = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        rr_ptr_d = addr_q + AW'(1);
        if (!rise) wr_cnt_d = wr_cnt_inc;
        if ((pending_q != '0) && (wr_cnt_inc < WCW'(MAX_WR)) && vblank)
          state_d = ST_GRANT;
        else
          state_d = ST_IDLE;
      end
`ifdef CELL_WR_INIT_EN
      ST_INIT: begin
        data_d = '0;
        if (addr_q == AW'(N - 1)) begin
          init_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ack_q        <= '0;
      vblank_q     <= 1'b0;
      frame_sync_q <= 1'b0;
`ifdef CELL_WR_INIT_EN
      init_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack_q        <= bus.req;
      vblank_q     <= vblank;
      frame_sync_q <= rise;
`ifdef CELL_WR_INIT_EN
      init_q       <= init_d;
`endif
    end
  end

  // Colour shadow registers; the latest request's colour wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.req[i]) shadow_q[i] <= bus.cell_color[i*DW +: DW];
    end
  end

  assign bus.ack         = ack_q;
  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_data = data_q;
  assign bus.px_wr       = (state_q == ST_WRITE) || (state_q == ST_INIT);
  assign bus.busy        = (pending_q != '0) || (state_q != ST_IDLE);
  assign bus.frame_sync  = frame_sync_q;
endmodule

// File: tb/tb_cell_wr_scheduler.sv
// Directed bench for cell_wr_scheduler (instance built with MAX_WR=2).
module tb_cell_wr_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   wa[$];
  int   wd[$];

  cell_wr_if #(.AW(3), .DW(3)) bus ();

  cell_wr_scheduler #(.AW(3), .DW(3), .V_ACTIVE(480), .MAX_WR(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  req;
    logic [23:0] col;
    logic [8:0]  posy;
    logic [7:0]  ack;
    logic        px_wr;
    logic [2:0]  addr;
    logic [2:0]  data;
    logic        busy;
    logic        fs;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [23:0] c, input logic [8:0] y);
    bus.req        = r;
    bus.cell_color = c;
    bus.vga_posY   = y;
  endtask

`ifdef CELL_WR_INIT_EN
  task automatic init_check();
    int first;
    int n;
    first = -1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (bus.px_wr) begin
        if (first < 0) first = c;
        chk("init_addr", 32'(bus.mem_px_addr), 32'(n));
        chk("init_data", 32'(bus.mem_px_data), 32'd0);
        chk("init_consec", 32'(c - first), 32'(n));
        chk("init_busy", 32'(bus.busy), 32'd1);
        n++;
      end
    end
    chk("init_count", 32'(n), 32'd8);
  endtask
`endif

  task automatic do_reset();
    rst = 1'b0;
    drive(8'h00, 24'h0, 9'd100);
    cyc();
    cyc();
    chk("rst_ack",   32'(bus.ack),         32'd0);
    chk("rst_px_wr", 32'(bus.px_wr),       32'd0);
    chk("rst_addr",  32'(bus.mem_px_addr), 32'd0);
    chk("rst_data",  32'(bus.mem_px_data), 32'd0);
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_fs",    32'(bus.frame_sync),  32'd0);
    rst = 1'b1;
`ifdef CELL_WR_INIT_EN
    init_check();
`endif
    cyc();
  endtask

  // One blanking interval of 12 lines' worth of cycles, then back to active video.
  task automatic blank_frame();
    wa.delete();
    wd.delete();
    bus.req = 8'h00;
    bus.vga_posY = 9'd480;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (bus.px_wr) begin
        wa.push_back(int'(bus.mem_px_addr));
        wd.push_back(int'(bus.mem_px_data));
      end
    end
    bus.vga_posY = 9'd100;
    for (int c = 0; c < 2; c++) begin
      cyc();
      if (bus.px_wr) begin
        wa.push_back(int'(bus.mem_px_addr));
        wd.push_back(int'(bus.mem_px_data));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(8'h00, 24'h0, 9'd100);

    //          req    colour      posY    ack   wr    addr  data  busy  fs
    tv[0]  = '{8'h05, 24'h000107, 9'd100, 8'h05, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    tv[1]  = '{8'h00, 24'h000000, 9'd100, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    tv[2]  = '{8'h00, 24'h000000, 9'd480, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1};
    tv[3]  = '{8'h00, 24'h000000, 9'd481, 8'h00, 1'b1, 3'd0, 3'd7, 1'b1, 1'b0};
    tv[4]  = '{8'h00, 24'h000000, 9'd482, 8'h00, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0};
    tv[5]  = '{8'h00, 24'h000000, 9'd483, 8'h00, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0};
    tv[6]  = '{8'h00, 24'h000000, 9'd484, 8'h00, 1'b0, 3'd2, 3'd4, 1'b0, 1'b0};
    tv[7]  = '{8'h00, 24'h000000, 9'd100, 8'h00, 1'b0, 3'd2, 3'd4, 1'b0, 1'b0};
    tv[8]  = '{8'h81, 24'hA00002, 9'd100, 8'h81, 1'b0, 3'd2, 3'd4, 1'b1, 1'b0};
    tv[9]  = '{8'h00, 24'h000000, 9'd480, 8'h00, 1'b0, 3'd2, 3'd4, 1'b1, 1'b1};
    tv[10] = '{8'h00, 24'h000000, 9'd481, 8'h00, 1'b1, 3'd7, 3'd5, 1'b1, 1'b0};
    tv[11] = '{8'h00, 24'h000000, 9'd482, 8'h00, 1'b0, 3'd7, 3'd5, 1'b1, 1'b0};
    tv[12] = '{8'h00, 24'h000000, 9'd483, 8'h00, 1'b1, 3'd0, 3'd2, 1'b1, 1'b0};
    tv[13] = '{8'h00, 24'h000000, 9'd484, 8'h00, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0};
    tv[14] = '{8'h00, 24'h000000, 9'd100, 8'h00, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0};

    do_reset();

    // Basic two-cell burst, then round-robin wrap from rr_ptr=3.
    for (int i = 0; i < 15; i++) begin
      logic chk_addr;
      chk_addr = 1'b1;
`ifdef CELL_WR_INIT_EN
      chk_addr = (i >= 3);
`endif
      drive(tv[i].req, tv[i].col, tv[i].posy);
      cyc();
      chk($sformatf("v%0d_ack", i),   32'(bus.ack),        32'(tv[i].ack));
      chk($sformatf("v%0d_px_wr", i), 32'(bus.px_wr),      32'(tv[i].px_wr));
      if (chk_addr)
        chk($sformatf("v%0d_addr", i), 32'(bus.mem_px_addr), 32'(tv[i].addr));
      chk($sformatf("v%0d_data", i),  32'(bus.mem_px_data), 32'(tv[i].data));
      chk($sformatf("v%0d_busy", i),  32'(bus.busy),       32'(tv[i].busy));
      chk($sformatf("v%0d_fs", i),    32'(bus.frame_sync), 32'(tv[i].fs));
    end

    // MAX_WR=2: all eight cells spread over four blanking intervals.
    do_reset();
    drive(8'hFF, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 9'd100);
    cyc();
    chk("all_ack", 32'(bus.ack), 32'hFF);
    bus.req = 8'h00;
    for (int f = 0; f < 4; f++) begin
      blank_frame();
      chk($sformatf("f%0d_nwr", f), 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
        chk($sformatf("f%0d_a0", f), 32'(wa[0]), 32'(2*f));
        chk($sformatf("f%0d_a1", f), 32'(wa[1]), 32'(2*f+1));
        chk($sformatf("f%0d_d0", f), 32'(wd[0]), 32'(2*f));
        chk($sformatf("f%0d_d1", f), 32'(wd[1]), 32'(2*f+1));
      end
      chk($sformatf("f%0d_busy", f), 32'(bus.busy), (f < 3) ? 32'd1 : 32'd0);
    end

    // Repeated request before blanking: only the last colour is written.
    drive(8'h10, 24'h002000, 9'd100);
    cyc();
    drive(8'h10, 24'h001000, 9'd100);
    cyc();
    blank_frame();
    chk("rep_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("rep_addr", 32'(wa[0]), 32'd4);
      chk("rep_data", 32'(wd[0]), 32'd1);
    end
    chk("rep_busy", 32'(bus.busy), 32'd0);

    // Request collides with GRANT of the same cell: old data written, cell rewritten.
    drive(8'h20, 24'h018000, 9'd100);
    cyc();
    drive(8'h00, 24'h000000, 9'd480);
    cyc();
    chk("col_fs", 32'(bus.frame_sync), 32'd1);
    drive(8'h20, 24'h030000, 9'd480);
    cyc();
    chk("col_wr1",   32'(bus.px_wr),       32'd1);
    chk("col_addr1", 32'(bus.mem_px_addr), 32'd5);
    chk("col_data1", 32'(bus.mem_px_data), 32'd3);
    chk("col_ack",   32'(bus.ack),         32'h20);
    drive(8'h00, 24'h000000, 9'd480);
    cyc();
    chk("col_gap",   32'(bus.px_wr),       32'd0);
    chk("col_busy1", 32'(bus.busy),        32'd1);
    cyc();
    chk("col_wr2",   32'(bus.px_wr),       32'd1);
    chk("col_addr2", 32'(bus.mem_px_addr), 32'd5);
    chk("col_data2", 32'(bus.mem_px_data), 32'd6);
    cyc();
    chk("col_busy2", 32'(bus.busy),        32'd0);
    bus.vga_posY = 9'd100;
    cyc();

    // Reset asserted during the first WRITE of a four-cell burst.
    drive(8'h0F, {12'h000, 3'd4, 3'd3, 3'd2, 3'd1}, 9'd100);
    cyc();
    drive(8'h00, 24'h000000, 9'd480);
    cyc();
    cyc();
    chk("mid_wr",   32'(bus.px_wr),       32'd1);
    chk("mid_addr", 32'(bus.mem_px_addr), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_wr",   32'(bus.px_wr),       32'd0);
    chk("abort_addr", 32'(bus.mem_px_addr), 32'd0);
    chk("abort_data", 32'(bus.mem_px_data), 32'd0);
    chk("abort_busy", 32'(bus.busy),        32'd0);
    chk("abort_fs",   32'(bus.frame_sync),  32'd0);
    cyc();
    cyc();
    rst = 1'b1;
`ifdef CELL_WR_INIT_EN
    init_check();
`endif
    bus.vga_posY = 9'd100;
    cyc();
    blank_frame();
    chk("post_rst_nwr",  32'(wa.size()), 32'd0);
    chk("post_rst_busy", 32'(bus.busy),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
